qmem_arbiter: RTL and testbench
===============================

// Module: qmem_arbiter
// PURPOSE
//  Two-master round-robin QMEM arbiter with a bus watchdog. Sits directly upstream of the QMEM
//  frequency-down bridge and drives its qm_* port. Typical masters: CPU instruction and data
//  ports. Grant is held for a whole transfer. A stalled slave is aborted with an error response.
// PARAMETERS
//  QAW  32      address width
//  QDW  32      data width
//  QSW  QDW/8   byte-select width
//  TOW  8       watchdog counter width
//  TO   200     watchdog limit in BUSY cycles; 0 disables the watchdog
// PORTS
//  clk               in   1     single clock
//  rst_n             in   1     asynchronous, active-low reset
//  m0_cs / m1_cs     in   1     master chip-select (request)
//  m0_we / m1_we     in   1     write enable
//  m0_sel / m1_sel   in   QSW   byte select
//  m0_adr / m1_adr   in   QAW   address
//  m0_dat_w/m1_dat_w in   QDW   write data
//  m0_dat_r/m1_dat_r out  QDW   read data (both = qs_dat_r)
//  m0_ack / m1_ack   out  1     acknowledge, one cycle per transfer
//  m0_err / m1_err   out  1     error, one cycle per transfer
//  qs_cs, qs_we      out  1     slave chip-select, write enable
//  qs_sel            out  QSW   slave byte select
//  qs_adr            out  QAW   slave address
//  qs_dat_w          out  QDW   slave write data
//  qs_dat_r          in   QDW   slave read data
//  qs_ack, qs_err    in   1     slave acknowledge, error
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, gnt=0, last=1 (m0 wins first), to_cnt=0.
//    All outputs 0 while in reset.
//  - IDLE: qs_cs=0 and all acks/errs=0. If any mN_cs=1, gnt <= winner and state <= BUSY on the
//    next edge. Arbitration latency is 1 cycle.
//  - Winner: the single requester. If both request, winner = !last (round-robin).
//  - BUSY: qs_we, qs_sel, qs_adr and qs_dat_w mux from master gnt. qs_cs = m[gnt]_cs & ~timeout.
//    m[gnt]_ack = qs_ack & qs_cs. m[gnt]_err = (qs_err & qs_cs) | timeout.
//    The non-granted master's ack and err = 0.
//  - End of transfer (qs_cs & (qs_ack|qs_err)): last <= gnt, state <= IDLE, to_cnt <= 0.
//    Ack and err are combinational in the same cycle. A back-to-back request is re-arbitrated
//    in IDLE, so there is 1 bubble cycle between transfers.
//  - qs_ack and qs_err together: both are forwarded. It counts as a single transfer end.
//  - Master abort (m[gnt]_cs falls in BUSY with no ack): state <= IDLE and last is unchanged.
//    No ack or err is generated.
//  - Watchdog: to_cnt increments each BUSY cycle without ack/err and saturates at 2^TOW-1.
//    timeout = (TO!=0) & (to_cnt==TO). On timeout: qs_cs=0 and m[gnt]_err=1 for that cycle
//    only, last <= gnt, state <= IDLE, to_cnt <= 0.
//  - Write enable, select, address and write data are not registered. Only the grant and state
//    are registered, so the slave sees the master's live signals.
//  - Reset asserted mid-transfer: outputs drop asynchronously. No ack or err is issued for the
//    aborted transfer.
//  - TO must be < 2^TOW. This is checked by an elaboration-time assertion.
// STRUCTURE
//  - Shared package qmem_pkg: state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1.
//    The same package is used by other qmem arbiters and decoders.
//  - One natural sub-module: qmem_rr_pick2 (combinational 2-way round-robin picker; inputs req,
//    last; output gnt).
//  - The grant mux and watchdog stay inline.
// TESTING
//  1 Reset release, m0_cs=1 adr=0x100, slave acks 2 cycles into BUSY -> qs_cs rises cycle 1,
//    m0_ack=1 in cycle 3, m1_ack=0 throughout.
//  2 m0_cs and m1_cs both held with slave 1-cycle ack -> grants alternate m0,m1,m0,m1 with one
//    IDLE cycle between transfers.
//  3 m1 read, qs_dat_r=0xDEADBEEF with qs_err=1 -> m1_err=1 and m1_dat_r=0xDEADBEEF.
//    No m1_ack. Next winner is m0.
//  4 TO=4, slave never acks -> qs_cs high for 4 BUSY cycles, then in the 5th cycle qs_cs=0 and
//    m0_err=1 for 1 cycle. State returns to IDLE.
//  5 m1 granted, then m1_cs drops before ack -> IDLE next cycle, no ack or err, and m1 stays
//    preferred in a later tie.
//  6 rst_n pulsed low mid-BUSY -> qs_cs and all acks=0 immediately. After release, m0 wins a
//    tie.

Source files
------------

// File: rtl/qmem_pkg.sv
// Shared QMEM definitions: the arbiter state encoding, reused by the other
// QMEM arbiters and decoders.
package qmem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } qmem_state_e;

endpackage

// File: rtl/qmem_rr_pick2.sv
// Combinational two-way round-robin picker. A lone requester wins; on a tie
// the master that was not served last wins.
module qmem_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = 1'b0;
    unique case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/qmem_arbiter.sv
// Two-master round-robin QMEM arbiter with a bus watchdog. Grant is held for a
// whole transfer; a stalled slave is aborted with a one-cycle error.
module qmem_arbiter
  import qmem_pkg::*;
#(
  parameter int unsigned QAW = 32,
  parameter int unsigned QDW = 32,
  parameter int unsigned QSW = QDW/8,
  parameter int unsigned TOW = 8,
  parameter int unsigned TO  = 200
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           m0_cs,
  input  logic           m0_we,
  input  logic [QSW-1:0] m0_sel,
  input  logic [QAW-1:0] m0_adr,
  input  logic [QDW-1:0] m0_dat_w,
  output logic [QDW-1:0] m0_dat_r,
  output logic           m0_ack,
  output logic           m0_err,
  input  logic           m1_cs,
  input  logic           m1_we,
  input  logic [QSW-1:0] m1_sel,
  input  logic [QAW-1:0] m1_adr,
  input  logic [QDW-1:0] m1_dat_w,
  output logic [QDW-1:0] m1_dat_r,
  output logic           m1_ack,
  output logic           m1_err,
  output logic           qs_cs,
  output logic           qs_we,
  output logic [QSW-1:0] qs_sel,
  output logic [QAW-1:0] qs_adr,
  output logic [QDW-1:0] qs_dat_w,
  input  logic [QDW-1:0] qs_dat_r,
  input  logic           qs_ack,
  input  logic           qs_err
);

  if (TO >= (64'd1 << TOW)) begin : g_to_check
    $error("qmem_arbiter: TO must be below 2**TOW");
  end

  qmem_state_e    state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  logic [1:0] req;
  logic       pick_gnt;
  logic       busy;
  logic       gnt_cs;
  logic       timeout;
  logic       ack;
  logic       err;

  assign req = {m1_cs, m0_cs};

  qmem_rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  assign busy    = (state_q == ST_BUSY);
  assign gnt_cs  = gnt_q ? m1_cs : m0_cs;
  assign timeout = busy && (TO != 0) && (to_cnt_q == TOW'(TO));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    to_cnt_d = to_cnt_q;
    qs_cs    = 1'b0;
    qs_we    = 1'b0;
    qs_sel   = '0;
    qs_adr   = '0;
    qs_dat_w = '0;
    ack      = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d    = pick_gnt;
          state_d  = ST_BUSY;
          to_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        qs_we    = gnt_q ? m1_we    : m0_we;
        qs_sel   = gnt_q ? m1_sel   : m0_sel;
        qs_adr   = gnt_q ? m1_adr   : m0_adr;
        qs_dat_w = gnt_q ? m1_dat_w : m0_dat_w;
        qs_cs    = gnt_cs & ~timeout;
        ack      = qs_ack & qs_cs;
        err      = (qs_err & qs_cs) | timeout;
        if (timeout || (qs_cs && (qs_ack || qs_err))) begin
          state_d  = ST_IDLE;
          last_d   = gnt_q;
          to_cnt_d = '0;
        end else if (!gnt_cs) begin
          // master abort: no response, and round-robin history is untouched
          state_d  = ST_IDLE;
          to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign m0_ack   = ack & ~gnt_q;
  assign m1_ack   = ack &  gnt_q;
  assign m0_err   = err & ~gnt_q;
  assign m1_err   = err &  gnt_q;
  assign m0_dat_r = qs_dat_r;
  assign m1_dat_r = qs_dat_r;

endmodule

// File: tb/tb_qmem_arbiter.sv
// Directed bench for qmem_arbiter: transfers, round-robin, slave error,
// watchdog timeout, master abort and asynchronous reset.
module tb_qmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cs, m0_we, m1_cs, m1_we;
  logic [3:0]  m0_sel, m1_sel, qs_sel;
  logic [31:0] m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        qs_cs, qs_we, qs_ack, qs_err;
  logic [31:0] qs_adr, qs_dat_w, qs_dat_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qmem_arbiter #(.QAW(32), .QDW(32), .QSW(4), .TOW(8), .TO(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cs(m0_cs), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cs(m1_cs), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr),
    .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_cs = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h100; m0_dat_w = 32'h11223344;
    m1_cs = 0; m1_we = 0; m1_sel = 4'h3; m1_adr = 32'h200; m1_dat_w = 32'h55667788;
    qs_dat_r = '0; qs_ack = 0; qs_err = 0;
    tick();
    chk("rst_qs_cs", qs_cs, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m0_err", m0_err, 0);
    chk("rst_qs_adr", qs_adr, 0);
    tick();
    rst_n = 1'b1;

    // 1: m0 transfer, slave acks in the third BUSY cycle
    m0_cs = 1; m0_we = 1;
    #1;
    chk("t1_idle_qs_cs", qs_cs, 0);
    tick();
    chk("t1_c1_qs_cs", qs_cs, 1);
    chk("t1_c1_qs_adr", qs_adr, 32'h100);
    chk("t1_c1_qs_dat_w", qs_dat_w, 32'h11223344);
    chk("t1_c1_qs_we", qs_we, 1);
    chk("t1_c1_m0_ack", m0_ack, 0);
    tick();
    chk("t1_c2_qs_cs", qs_cs, 1);
    chk("t1_c2_m0_ack", m0_ack, 0);
    tick();
    qs_ack = 1;
    #1;
    chk("t1_c3_m0_ack", m0_ack, 1);
    chk("t1_c3_m1_ack", m1_ack, 0);
    tick();
    m0_cs = 0; m0_we = 0; qs_ack = 0;
    #1;
    chk("t1_end_qs_cs", qs_cs, 0);
    chk("t1_end_m0_ack", m0_ack, 0);

    // 2: both request with 1-cycle slave ack; last was m0 so m1 goes first
    m0_cs = 1; m1_cs = 1; qs_ack = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_bubble_qs_cs", qs_cs, 0);
      chk("t2_bubble_ack", {m1_ack, m0_ack}, 0);
      tick();
      chk("t2_adr", qs_adr, (k % 2 == 0) ? 32'h200 : 32'h100);
      chk("t2_m0_ack", m0_ack, (k % 2 == 0) ? 0 : 1);
      chk("t2_m1_ack", m1_ack, (k % 2 == 0) ? 1 : 0);
      tick();
    end
    m0_cs = 0; m1_cs = 0; qs_ack = 0;

    // 3: m1 read answered with a slave error; next tie goes to m0
    m1_cs = 1;
    tick();
    qs_err = 1; qs_dat_r = 32'hDEADBEEF;
    #1;
    chk("t3_m1_err", m1_err, 1);
    chk("t3_m1_ack", m1_ack, 0);
    chk("t3_m0_err", m0_err, 0);
    chk("t3_m1_dat_r", m1_dat_r, 32'hDEADBEEF);
    tick();
    qs_err = 0; qs_dat_r = '0;
    m0_cs = 1; m1_cs = 1;
    tick();
    chk("t3_next_adr", qs_adr, 32'h100);
    qs_ack = 1;
    #1;
    chk("t3_next_m0_ack", m0_ack, 1);
    tick();
    m0_cs = 0; m1_cs = 0; qs_ack = 0;

    // 4: slave never answers, watchdog fires in the fifth BUSY cycle
    m0_cs = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_busy_qs_cs", qs_cs, 1);
      chk("t4_busy_m0_err", m0_err, 0);
      tick();
    end
    chk("t4_to_qs_cs", qs_cs, 0);
    chk("t4_to_m0_err", m0_err, 1);
    chk("t4_to_m1_err", m1_err, 0);
    tick();
    chk("t4_idle_qs_cs", qs_cs, 0);
    chk("t4_idle_m0_err", m0_err, 0);
    m0_cs = 0;

    // 5: m1 aborts; m1 must still win the next tie
    m1_cs = 1;
    tick();
    chk("t5_qs_cs", qs_cs, 1);
    chk("t5_adr", qs_adr, 32'h200);
    m1_cs = 0;
    #1;
    chk("t5_abort_qs_cs", qs_cs, 0);
    chk("t5_abort_resp", {m1_err, m1_ack}, 0);
    tick();
    m0_cs = 1; m1_cs = 1;
    #1;
    chk("t5_idle_qs_cs", qs_cs, 0);
    tick();
    chk("t5_tie_adr", qs_adr, 32'h200);
    qs_ack = 1;
    #1;
    chk("t5_tie_m1_ack", m1_ack, 1);
    tick();
    m0_cs = 0; m1_cs = 0; qs_ack = 0;

    // 6: reset mid-transfer; afterwards m0 wins a tie
    m0_cs = 1; qs_ack = 1;
    tick();
    chk("t6_m0_ack", m0_ack, 1);
    tick();
    m0_cs = 0; qs_ack = 0; m1_cs = 1;
    tick();
    chk("t6_busy_qs_cs", qs_cs, 1);
    #2;
    qs_ack = 1; rst_n = 1'b0;
    #1;
    chk("t6_rst_qs_cs", qs_cs, 0);
    chk("t6_rst_acks", {m1_ack, m0_ack}, 0);
    chk("t6_rst_qs_adr", qs_adr, 0);
    qs_ack = 0; m0_cs = 1;
    tick();
    #3;
    rst_n = 1'b1;
    #1;
    chk("t6_rel_qs_cs", qs_cs, 0);
    tick();
    chk("t6_tie_adr", qs_adr, 32'h100);
    chk("t6_tie_qs_cs", qs_cs, 1);
    m0_cs = 0; m1_cs = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
